// File: rtl/rv32i_pkg.sv
// Shared RV32I branch definitions: funct3 codes, compare-unit result codes,
// branch resolver state encoding and a small alignment helper.
package rv32i_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] CMP_NONE = 2'b00;
  localparam logic [1:0] CMP_EQ   = 2'b01;
  localparam logic [1:0] CMP_GT   = 2'b10;
  localparam logic [1:0] CMP_LT   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_CMP = 2'd1,
    ST_RESOLVE  = 2'd2,
    ST_FLUSH    = 2'd3
  } br_state_e;

  // A branch target is usable only when it lands on a 32-bit boundary.
  function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
    return (addr_lsb == 2'b00);
  endfunction

endpackage

// File: rtl/branch_cond_decode.sv
// Combinational branch condition evaluation from the unsigned compare code,
// with the signed correction derived from the operand sign bits.
module branch_cond_decode
  import rv32i_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic [1:0] cmp_code_i,
  input  logic       sign_1_i,
  input  logic       sign_2_i,
  output logic       taken_o,
  output logic       illegal_o
);

  logic eq_s;
  logic ltu_s;
  logic lts_s;

  // Evaluate eq/ltu/lts and select the condition for the branch type.
  always_comb begin
    eq_s      = (cmp_code_i == CMP_EQ);
    ltu_s     = (cmp_code_i == CMP_LT);
    // Differing signs decide the signed order by themselves.
    lts_s     = (sign_1_i != sign_2_i) ? sign_1_i : ltu_s;
    taken_o   = 1'b0;
    illegal_o = 1'b0;
    case (funct3_i)
      F3_BEQ:  taken_o = eq_s;
      F3_BNE:  taken_o = !eq_s;
      F3_BLT:  taken_o = lts_s;
      F3_BGE:  taken_o = !lts_s;
      F3_BLTU: taken_o = ltu_s;
      F3_BGEU: taken_o = !ltu_s;
      default: illegal_o = 1'b1;
    endcase
    // A missing compare result can never produce a taken branch.
    if (cmp_code_i == CMP_NONE) begin
      taken_o   = 1'b0;
      illegal_o = 1'b1;
    end else begin
      illegal_o = illegal_o;
    end
  end

endmodule

// File: rtl/branch_resolver.sv
// RV32I conditional branch resolver: accepts a request, waits one cycle for
// the compare unit, pulses the outcome and redirect, then holds flush.
// Optional feature macro: BRANCH_STATS_EN adds saturating taken/not-taken
// counters on stat_taken_o / stat_not_taken_o.
module branch_resolver
  import rv32i_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [2:0]       funct3_i,
  input  logic [WIDTH-1:0] pc_i,
  input  logic [WIDTH-1:0] imm_i,
  input  logic             sign_1_i,
  input  logic             sign_2_i,
  output logic             cmp_en_o,
  input  logic [1:0]       cmp_code_i,
  output logic             resolved_valid_o,
  output logic             resolved_taken_o,
  output logic             redirect_valid_o,
  output logic [WIDTH-1:0] redirect_pc_o,
  output logic             flush_o,
  output logic             misalign_o,
  output logic             illegal_o,
  output logic             busy_o
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]      stat_taken_o,
  output logic [31:0]      stat_not_taken_o
`endif
);

  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

  br_state_e        state_q, state_d;
  logic [2:0]       funct3_q, funct3_d;
  logic             sign1_q, sign1_d;
  logic             sign2_q, sign2_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [WIDTH-1:0] fallthru_q, fallthru_d;
  logic             taken_q, taken_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dec_taken_s;
  logic             dec_illegal_s;

  branch_cond_decode u_cond (
    .funct3_i   (funct3_q),
    .cmp_code_i (cmp_code_i),
    .sign_1_i   (sign1_q),
    .sign_2_i   (sign2_q),
    .taken_o    (dec_taken_s),
    .illegal_o  (dec_illegal_s)
  );

  // State and request-context registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      funct3_q   <= 3'd0;
      sign1_q    <= 1'b0;
      sign2_q    <= 1'b0;
      target_q   <= '0;
      fallthru_q <= '0;
      taken_q    <= 1'b0;
      illegal_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      funct3_q   <= funct3_d;
      sign1_q    <= sign1_d;
      sign2_q    <= sign2_d;
      target_q   <= target_d;
      fallthru_q <= fallthru_d;
      taken_q    <= taken_d;
      illegal_q  <= illegal_d;
      cnt_q      <= cnt_d;
    end
  end

  // Next-state logic and outputs decoded from the current state.
  always_comb begin
    state_d          = state_q;
    funct3_d         = funct3_q;
    sign1_d          = sign1_q;
    sign2_d          = sign2_q;
    target_d         = target_q;
    fallthru_d       = fallthru_q;
    taken_d          = taken_q;
    illegal_d        = illegal_q;
    cnt_d            = cnt_q;
    req_ready_o      = 1'b0;
    cmp_en_o         = 1'b0;
    resolved_valid_o = 1'b0;
    resolved_taken_o = 1'b0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = '0;
    flush_o          = 1'b0;
    misalign_o       = 1'b0;
    illegal_o        = 1'b0;
    busy_o           = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        req_ready_o = !rst;
        if (req_valid_i && !rst) begin
          // Operands are on the compare unit's inputs this very cycle.
          cmp_en_o   = 1'b1;
          funct3_d   = funct3_i;
          sign1_d    = sign_1_i;
          sign2_d    = sign_2_i;
          target_d   = pc_i + imm_i;
          fallthru_d = pc_i + WIDTH'(32'd4);
          state_d    = ST_WAIT_CMP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_CMP: begin
        taken_d   = dec_taken_s;
        illegal_d = dec_illegal_s;
        state_d   = ST_RESOLVE;
      end
      ST_RESOLVE: begin
        resolved_valid_o = 1'b1;
        resolved_taken_o = taken_q;
        illegal_o        = illegal_q;
        if (taken_q && is_word_aligned(target_q[1:0])) begin
          redirect_valid_o = 1'b1;
          redirect_pc_o    = target_q;
          cnt_d            = CNT_W'(FLUSH_CYCLES);
          state_d          = ST_FLUSH;
        end else if (taken_q) begin
          misalign_o    = 1'b1;
          redirect_pc_o = target_q;
          state_d       = ST_IDLE;
        end else begin
          // Fall-through is shown for debug visibility only.
          redirect_pc_o = fallthru_q;
          state_d       = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        flush_o = 1'b1;
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

`ifdef BRANCH_STATS_EN
  logic [31:0] stat_taken_q;
  logic [31:0] stat_not_taken_q;

  // Saturating outcome counters, bumped once per resolved branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_taken_q     <= 32'd0;
      stat_not_taken_q <= 32'd0;
    end else if (state_q == ST_RESOLVE) begin
      if (taken_q && !(&stat_taken_q)) begin
        stat_taken_q <= stat_taken_q + 32'd1;
      end else if (!taken_q && !(&stat_not_taken_q)) begin
        stat_not_taken_q <= stat_not_taken_q + 32'd1;
      end
    end
  end

  assign stat_taken_o     = stat_taken_q;
  assign stat_not_taken_o = stat_not_taken_q;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: expected outcomes are computed from
// real operand values, queued at issue time and checked on resolved_valid.
module tb_branch_resolver;

  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [2:0]  funct3_i;
  logic [31:0] pc_i;
  logic [31:0] imm_i;
  logic        sign_1_i;
  logic        sign_2_i;
  logic        cmp_en_o;
  logic [1:0]  cmp_code_i;
  logic        resolved_valid_o;
  logic        resolved_taken_o;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;
  logic        flush_o;
  logic        misalign_o;
  logic        illegal_o;
  logic        busy_o;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_taken_o;
  logic [31:0] stat_not_taken_o;
`endif

  typedef struct {
    logic        taken;
    logic        redirect;
    logic        misalign;
    logic        illegal;
    logic [31:0] pc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   flush_left = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  branch_resolver #(.WIDTH(32), .FLUSH_CYCLES(FC)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .funct3_i         (funct3_i),
    .pc_i             (pc_i),
    .imm_i            (imm_i),
    .sign_1_i         (sign_1_i),
    .sign_2_i         (sign_2_i),
    .cmp_en_o         (cmp_en_o),
    .cmp_code_i       (cmp_code_i),
    .resolved_valid_o (resolved_valid_o),
    .resolved_taken_o (resolved_taken_o),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o),
    .flush_o          (flush_o),
    .misalign_o       (misalign_o),
    .illegal_o        (illegal_o),
    .busy_o           (busy_o)
`ifdef BRANCH_STATS_EN
    ,
    .stat_taken_o     (stat_taken_o),
    .stat_not_taken_o (stat_not_taken_o)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Builds the expected result from operand values, then drives the request.
  task automatic issue(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                       input logic [31:0] rs1, input logic [31:0] rs2,
                       input bit code_none, input bit wait_done);
    exp_t e;
    logic [1:0]  code;
    logic [31:0] tgt;
    logic        legal;
    logic        t;
    code  = code_none ? 2'b00 : (rs1 == rs2) ? 2'b01 : (rs1 > rs2) ? 2'b10 : 2'b11;
    legal = !code_none && (f3 != 3'b010) && (f3 != 3'b011);
    case (f3)
      3'b000:  t = (rs1 == rs2);
      3'b001:  t = (rs1 != rs2);
      3'b100:  t = ($signed(rs1) <  $signed(rs2));
      3'b101:  t = ($signed(rs1) >= $signed(rs2));
      3'b110:  t = (rs1 <  rs2);
      3'b111:  t = (rs1 >= rs2);
      default: t = 1'b0;
    endcase
    t          = t && legal;
    tgt        = pc + imm;
    e.taken    = t;
    e.illegal  = !legal;
    e.misalign = t && (tgt[1:0] != 2'b00);
    e.redirect = t && !e.misalign;
    e.pc       = t ? tgt : pc + 32'd4;
    sb_q.push_back(e);
    @(negedge clk);
    req_valid_i = 1'b1;
    funct3_i    = f3;
    pc_i        = pc;
    imm_i       = imm;
    sign_1_i    = rs1[31];
    sign_2_i    = rs2[31];
    #1;
    check_eq("accept_ready", req_ready_o, 1);
    check_eq("accept_cmp_en", cmp_en_o, 1);
    @(negedge clk);
    req_valid_i = 1'b0;
    cmp_code_i  = code;
    #1;
    check_eq("wait_busy", busy_o, 1);
    check_eq("wait_cmp_en", cmp_en_o, 0);
    @(negedge clk);
    cmp_code_i = 2'b00;
    if (wait_done) wait_idle();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && busy_o; i++) @(negedge clk);
    if (busy_o) check_eq("idle_timeout", busy_o, 0);
    check_eq("idle_ready", req_ready_o, 1);
  endtask

  // Monitor: compares every resolution against the scoreboard and tracks flush.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        flush_left = 0;
      end else if (resolved_valid_o) begin
        if (sb_q.size() == 0) begin
          check_eq("sb_underflow", 1, 0);
        end else begin
          mon_e = sb_q.pop_front();
          check_eq("res_taken", resolved_taken_o, mon_e.taken);
          check_eq("res_redirect", redirect_valid_o, mon_e.redirect);
          check_eq("res_misalign", misalign_o, mon_e.misalign);
          check_eq("res_illegal", illegal_o, mon_e.illegal);
          check_eq("res_flush_low", flush_o, 0);
          if (!mon_e.misalign) check_eq("res_pc", redirect_pc_o, mon_e.pc);
          flush_left = mon_e.redirect ? FC : 0;
        end
      end else begin
        if (flush_left > 0) begin
          check_eq("flush_hold", flush_o, 1);
          flush_left--;
        end else if (flush_o) begin
          check_eq("flush_spurious", flush_o, 0);
        end
        if (redirect_valid_o || misalign_o || illegal_o)
          check_eq("stray_pulse", {redirect_valid_o, misalign_o, illegal_o}, 0);
      end
    end
  end

  initial begin
    rst = 1'b1; req_valid_i = 1'b0; funct3_i = 3'd0; pc_i = 32'd0; imm_i = 32'd0;
    sign_1_i = 1'b0; sign_2_i = 1'b0; cmp_code_i = 2'b00;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_ready", req_ready_o, 0);
    check_eq("rst_busy", busy_o, 0);
    check_eq("rst_flush", flush_o, 0);
    check_eq("rst_redirect_pc", redirect_pc_o, 0);
    check_eq("rst_resolved", resolved_valid_o, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("post_rst_ready", req_ready_o, 1);

    // Directed cases from the plan plus signed/unsigned corners.
    issue(3'b000, 32'h0000_0100, 32'h0000_0020, 32'd5, 32'd5, 1'b0, 1'b1);
    issue(3'b100, 32'h0000_0300, 32'h0000_0040, 32'h8000_0000, 32'd1, 1'b0, 1'b1);
    issue(3'b110, 32'h0000_0300, 32'h0000_0040, 32'h8000_0000, 32'd1, 1'b0, 1'b1);
    issue(3'b111, 32'hFFFF_FFF0, 32'h0000_0020, 32'd9, 32'd3, 1'b0, 1'b1);
    issue(3'b001, 32'h0000_0400, 32'h0000_0002, 32'd1, 32'd2, 1'b0, 1'b1);
    issue(3'b010, 32'h0000_0500, 32'h0000_0010, 32'd4, 32'd4, 1'b0, 1'b1);
    issue(3'b011, 32'h0000_0500, 32'h0000_0010, 32'd4, 32'd7, 1'b0, 1'b1);
    issue(3'b000, 32'h0000_0600, 32'h0000_0010, 32'd4, 32'd4, 1'b1, 1'b1);
    issue(3'b101, 32'h0000_0700, 32'h0000_0008, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b1);
    issue(3'b101, 32'h0000_0700, 32'h0000_0008, 32'd3, 32'd7, 1'b0, 1'b1);
    issue(3'b100, 32'h0000_0800, 32'h0000_0010, 32'hFFFF_FFFB, 32'hFFFF_FFFD, 1'b0, 1'b1);
    issue(3'b000, 32'h0000_1000, 32'hFFFF_FFF0, 32'd0, 32'd0, 1'b0, 1'b1);

    // Randomised legal branches.
    for (int i = 0; i < 16; i++) begin
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      case ($urandom_range(0, 5))
        0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b100;
        3: f3 = 3'b101; 4: f3 = 3'b110; default: f3 = 3'b111;
      endcase
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      issue(f3, $urandom & 32'hFFFF_FFFC, {$urandom_range(0, 2047), 1'b0}, a, b, 1'b0, 1'b1);
    end

    // Request held high while busy: only accepted at cycle 0 and 3+FC.
    sb_q.push_back('{taken: 1'b1, redirect: 1'b1, misalign: 1'b0, illegal: 1'b0, pc: 32'h0000_0240});
    sb_q.push_back('{taken: 1'b1, redirect: 1'b1, misalign: 1'b0, illegal: 1'b0, pc: 32'h0000_0240});
    @(negedge clk);
    req_valid_i = 1'b1; funct3_i = 3'b000; pc_i = 32'h0000_0200; imm_i = 32'h0000_0040;
    sign_1_i = 1'b0; sign_2_i = 1'b0; cmp_code_i = 2'b01;
    for (int c = 0; c <= 3 + FC; c++) begin
      #1;
      check_eq("hold_cmp_en", cmp_en_o, (c == 0 || c == 3 + FC) ? 1 : 0);
      check_eq("hold_ready", req_ready_o, (c == 0 || c == 3 + FC) ? 1 : 0);
      @(negedge clk);
    end
    req_valid_i = 1'b0;
    wait_idle();

    // Reset during FLUSH discards the remaining flush cycles.
    issue(3'b000, 32'h0000_0900, 32'h0000_0010, 32'd8, 32'd8, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    check_eq("pre_rst_flush", flush_o, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rstf_flush", flush_o, 0);
    check_eq("rstf_busy", busy_o, 0);
    check_eq("rstf_ready", req_ready_o, 0);
    check_eq("rstf_resolved", resolved_valid_o, 0);
    check_eq("rstf_redirect", redirect_valid_o, 0);
    check_eq("rstf_redirect_pc", redirect_pc_o, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rstf_ready_after", req_ready_o, 1);

`ifdef BRANCH_STATS_EN
    check_eq("stat_taken_clr", stat_taken_o, 0);
    check_eq("stat_nt_clr", stat_not_taken_o, 0);
    issue(3'b000, 32'h0000_0100, 32'h0000_0020, 32'd1, 32'd1, 1'b0, 1'b1);
    issue(3'b001, 32'h0000_0100, 32'h0000_0020, 32'd1, 32'd1, 1'b0, 1'b1);
    issue(3'b110, 32'h0000_0100, 32'h0000_0020, 32'd1, 32'd2, 1'b0, 1'b1);
    issue(3'b010, 32'h0000_0100, 32'h0000_0020, 32'd1, 32'd2, 1'b0, 1'b1);
    issue(3'b111, 32'h0000_0100, 32'h0000_0002, 32'd5, 32'd2, 1'b0, 1'b1);
    check_eq("stat_taken", stat_taken_o, 3);
    check_eq("stat_not_taken", stat_not_taken_o, 2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("stat_taken_rst", stat_taken_o, 0);
    check_eq("stat_nt_rst", stat_not_taken_o, 0);
`endif

    repeat (4) @(negedge clk);
    check_eq("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/branch_resolver.md
# branch_resolver

Consumes the registered 2-bit compare code from the branch compare unit and resolves RV32I conditional branches (BEQ/BNE/BLT/BGE/BLTU/BGEU). Computes the target as PC + imm and the fall-through as PC + 4, decides taken/not-taken, and issues a one-cycle PC redirect plus a multi-cycle pipeline flush. Sits between decode/issue, which supplies the request, and the fetch PC mux and pipeline-flush network.

## Interface
- `WIDTH`, 32, datapath and PC width.
- `FLUSH_CYCLES`, 2, cycles `flush` is held after a taken, aligned branch (≥1).
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  1  branch request valid.
- `req_ready`  out  1  resolver can accept a request.
- `funct3`  in  3  branch type.
- `pc`  in  WIDTH  address of the branch instruction.
- `imm`  in  WIDTH  sign-extended B-immediate.
- `sign_1`, `sign_2`  in  1  MSBs of rs1/rs2, used for the signed correction.
- `cmp_en`  out  1  enable to the compare unit.
- `cmp_code`  in  2  compare result: 01 eq, 10 gt (unsigned), 11 lt (unsigned), 00 reset/invalid.
- `resolved_valid`  out  1  one-cycle pulse when the result is available.
- `resolved_taken`  out  1  branch outcome, valid with `resolved_valid`.
- `redirect_valid`  out  1  one-cycle pulse to load `redirect_pc` into fetch.
- `redirect_pc`  out  WIDTH  target address.
- `flush`  out  1  squash younger instructions.
- `misalign`  out  1  pulse: taken branch with `target[1:0]` ≠ 0.
- `illegal`  out  1  pulse: `funct3` is 010 or 011, or `cmp_code` is 00.
- `busy`  out  1  state ≠ IDLE.

## Operation
- States are IDLE, WAIT_CMP, RESOLVE, FLUSH.
- **IDLE:** `req_ready` = 1. On `req_valid && req_ready`:
  - `cmp_en` = 1, combinationally in the same cycle. Upstream drives the compare operands in that cycle.
  - Latch `funct3`, `sign_1`, `sign_2`.
  - Latch `target` = (pc + imm) mod 2^WIDTH and `fallthru` = (pc + 4) mod 2^WIDTH.
  - Go to WAIT_CMP.
- **WAIT_CMP:** sample `cmp_code` and evaluate the condition:
  - eq = (code == 01); ltu = (code == 11).
  - lts = sign_1 if sign_1 ≠ sign_2, otherwise ltu.
  - BEQ: eq. BNE: !eq. BLT: lts. BGE: !lts. BLTU: ltu. BGEU: !ltu.
  - 010, 011, or code 00: not taken, and flag illegal.
  - Register the outcome and go to RESOLVE.
- **RESOLVE:** pulse `resolved_valid` with `resolved_taken`.
  - Taken and aligned: pulse `redirect_valid`, drive `redirect_pc` = target, load the flush counter with FLUSH_CYCLES, go to FLUSH.
  - Taken and misaligned: pulse `misalign`, no redirect, no flush, go to IDLE.
  - Not taken: go to IDLE. `redirect_pc` shows fallthru for debug only.
- **FLUSH:** `flush` = 1 and the counter decrements. When the counter reaches 1, go to IDLE.
- `req_ready` = 0 outside IDLE. Requests presented there are ignored; upstream holds them.

## Timing
- Acceptance occurs in cycle 0.
- `cmp_code` is sampled in cycle 1.
- `resolved_valid`, `redirect_valid`, `misalign` and `illegal` pulse in cycle 2.
- `flush` is high during cycles 3 … 2+FLUSH_CYCLES.
- The next request can be accepted in cycle 3 if the branch is not taken, or in cycle 3+FLUSH_CYCLES if it is taken.
- Reset values: all outputs 0 and `redirect_pc` = 0. `req_ready` = 0 while `rst` is high and 1 in the first cycle after reset.
- `rst` in any state returns to IDLE on the next edge. In-flight results are discarded and no pulse is emitted.
- PC arithmetic wraps modulo 2^WIDTH. No overflow flag is produced.

## Configuration
- `BRANCH_STATS_EN` defined: adds output ports `stat_taken` and `stat_not_taken` (both 32 bits).
  - Each counter increments in the RESOLVE cycle and saturates at 0xFFFF_FFFF.
  - Both counters clear on `rst`.
  - Illegal requests count as not taken.
- `BRANCH_STATS_EN` undefined: the counters and ports are absent, and behaviour is otherwise identical.

## Structure
- Shared package `rv32i_pkg` holds:
  - funct3 constants (`F3_BEQ` … `F3_BGEU`);
  - compare-code constants (`CMP_NONE` = 00, `CMP_EQ` = 01, `CMP_GT` = 10, `CMP_LT` = 11);
  - the state encoding.
- Sub-module `branch_cond_decode` is purely combinational: inputs funct3, cmp_code, sign_1, sign_2; outputs taken, illegal.

## Test plan
- BEQ, pc = 0x100, imm = 0x20, code 01 → cycle 2: `resolved_taken` = 1, `redirect_pc` = 0x120, redirect pulse; `flush` high in cycles 3–4.
- BLT with sign_1 = 1, sign_2 = 0, code 10 → taken (signed correction). Same request as BLTU → not taken, no redirect, no flush.
- BGEU, pc = 0xFFFF_FFF0, imm = 0x20, code 10 → `redirect_pc` = 0x0000_0010 (wrap-around).
- Taken BNE with imm = 0x2 → `misalign` pulse, `redirect_valid` = 0, `flush` = 0. Also: funct3 = 010 → `illegal` pulse, not taken.
- Assert `rst` while in FLUSH → next cycle IDLE, `flush` = 0, all outputs 0. `req_valid` held high during `busy` is accepted only once the FSM returns to IDLE.
- With `BRANCH_STATS_EN`: 3 taken and 2 not-taken branches → `stat_taken` = 3, `stat_not_taken` = 2. After `rst`, both are 0.
